bat_amateur_regfile: RTL and testbench
======================================

// Module: bat_amateur_regfile
// PURPOSE
//  General-register file driven by the controller's REGS_INC/REGS_RW/REGS_EN strobes.
//  Holds A, B, R3..R7 and OUT (index 0..7); loads from / drives the shared data bus.
//  Feeds A/B to the ALU and buffers OUT writes in a small FIFO toward the output device.
//  Acts on posedge CLK; the controller changes strobes on negedge, so strobes are stable here.
// PARAMETERS
//  DATA_W     8  register/bus width
//  OUT_DEPTH  4  OUT FIFO entries; power of two, >=2
// PORTS
//  CLK          in   1        system clock, all state on rising edge
//  RST          in   1        synchronous reset, active low
//  BUS_IN       in   DATA_W   shared data bus value
//  REGS_INC     in   8        per-register increment strobe (bit0=A ... bit7=OUT)
//  REGS_RW      in   8        per-register direction: 1=load from bus, 0=drive bus
//  REGS_EN      in   8        per-register enable
//  BUS_OUT      out  DATA_W   value of the register driving the bus, else 0
//  BUS_DRIVE    out  1        some register is driving BUS_OUT this cycle
//  REG_A        out  DATA_W   register A contents (to ALU)
//  REG_B        out  DATA_W   register B contents (to ALU)
//  OUT_DATA     out  DATA_W   head of OUT FIFO
//  OUT_VALID    out  1        OUT FIFO non-empty
//  OUT_READY    in   1        output device accepts OUT_DATA this cycle
//  OUT_OVERRUN  out  1        sticky: OUT push dropped because FIFO full
//  BUS_CONFLICT out  1        sticky: two or more registers drove the bus in one cycle
// BEHAVIOUR
//  Per register i (each rising edge, EN[i]=0 -> no action, register holds):
//   - EN&INC: reg <= reg+1 mod 2^DATA_W (0xFF->0x00); INC overrides RW; no drive, no push.
//   - EN&!INC&RW: reg <= BUS_IN.
//   - EN&!INC&!RW: register drives bus (combinational, same cycle).
//  Bus: BUS_OUT/BUS_DRIVE combinational from current strobes and register contents.
//   Multiple drivers -> BUS_OUT = lowest-index driver; BUS_CONFLICT set next edge.
//   No drivers -> BUS_OUT=0, BUS_DRIVE=0. Loads see BUS_IN, never BUS_OUT (no internal loop).
//  REG_A/REG_B: registered contents, new value visible the cycle after the load/inc edge.
//  OUT (index 7): load (EN7&!INC7&RW7) writes reg7 AND pushes BUS_IN into FIFO.
//   Reg7 remains readable onto bus regardless of FIFO state.
//  OUT FIFO: pop when OUT_VALID&OUT_READY; OUT_DATA = head entry, stable until popped.
//   Push when full and no pop -> data dropped, OUT_OVERRUN set (reg7 still updated).
//   Push+pop same edge when full -> both happen, no overrun; when empty -> push only
//    (pop ignored, OUT_VALID=0 that cycle); count unchanged on simultaneous push+pop.
//   Pointers wrap modulo OUT_DEPTH; count width clog2(OUT_DEPTH)+1.
//   OUT_READY with OUT_VALID=0 -> no effect. First-word latency: push edge -> OUT_VALID next cycle.
//  Reset (RST=0 at edge, overrides all strobes, may occur mid-transfer):
//   all registers 0, FIFO emptied (OUT_VALID=0, OUT_DATA=0), OUT_OVERRUN=0, BUS_CONFLICT=0.
//   BUS_OUT follows strobes combinationally even during reset (drives 0 contents).
//  Sticky flags clear only on reset.
// TESTING
//  1 Load: BUS_IN=0x5A, EN=0x01,RW=0x01 one edge; then EN=0x01,RW=0 -> BUS_OUT=0x5A, BUS_DRIVE=1, REG_A=0x5A.
//  2 Increment wrap: load B=0xFF, then EN=INC=0x02 (RW=1) -> REG_B=0x00, BUS_DRIVE=0, no load of BUS_IN.
//  3 Conflict: A=0x11,B=0x22, EN=0x03,RW=0 -> BUS_OUT=0x11 same cycle, BUS_CONFLICT=1 after edge, stays 1.
//  4 OUT FIFO: OUT_READY=0, push 0x01..0x05 -> OUT_VALID=1, OUT_DATA=0x01, OUT_OVERRUN=1 after 5th; drain -> 01,02,03,04 then OUT_VALID=0.
//  5 Full push+pop: FIFO full (4), push 0x99 with OUT_READY=1 -> no overrun, count stays 4, 0x99 popped last.
//  6 Reset mid-op: FIFO 2 deep, regs nonzero, RST=0 one edge with strobes active -> all regs 0, OUT_VALID=0, flags 0.

Source files
------------

// File: rtl/bat_amateur_regfile.sv
`default_nettype none
// ============================================================================
// Module      : bat_amateur_regfile
// Description : General-register file for the BAT amateur CPU. Holds A, B,
//               R3..R7 and OUT (indices 0..7). Each register is independently
//               incremented, loaded from the shared bus, or driven onto the bus
//               under control of the controller's per-register strobes. Writes
//               to OUT are also queued in a small FIFO toward the output device.
// Ports       :
//   CLK          in   system clock, all state on rising edge
//   RST          in   synchronous reset, active low
//   BUS_IN       in   shared data bus value (load source)
//   REGS_INC     in   per-register increment strobe (bit0=A ... bit7=OUT)
//   REGS_RW      in   per-register direction: 1=load from bus, 0=drive bus
//   REGS_EN      in   per-register enable
//   BUS_OUT      out  value of the lowest-index register driving the bus, else 0
//   BUS_DRIVE    out  some register is driving BUS_OUT this cycle
//   REG_A        out  register A contents
//   REG_B        out  register B contents
//   OUT_DATA     out  head of OUT FIFO (0 when empty)
//   OUT_VALID    out  OUT FIFO non-empty
//   OUT_READY    in   output device accepts OUT_DATA this cycle
//   OUT_OVERRUN  out  sticky: OUT push dropped because FIFO was full
//   BUS_CONFLICT out  sticky: two or more registers drove the bus in one cycle
// Revision    : 1.0 - initial release
// ============================================================================
module bat_amateur_regfile #(
    parameter int DATA_W    = 8,
    parameter int OUT_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] BUS_IN,
    input  logic [7:0]        REGS_INC,
    input  logic [7:0]        REGS_RW,
    input  logic [7:0]        REGS_EN,
    output logic [DATA_W-1:0] BUS_OUT,
    output logic              BUS_DRIVE,
    output logic [DATA_W-1:0] REG_A,
    output logic [DATA_W-1:0] REG_B,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic              OUT_OVERRUN,
    output logic              BUS_CONFLICT
);

    localparam int C_PTR_W = $clog2(OUT_DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;

    logic [DATA_W-1:0]  r_regs [8];
    logic [DATA_W-1:0]  r_fifo [OUT_DEPTH];
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_CNT_W-1:0] r_count;
    logic               r_overrun;
    logic               r_conflict;

    logic [7:0]         w_drive;
    logic [DATA_W-1:0]  w_bus_out;
    logic               w_multi_drive;
    logic               w_valid;
    logic               w_full;
    logic               w_push_req;
    logic               w_push;
    logic               w_pop;

    // INC has priority over RW, so a register only drives when neither
    // incrementing nor loading.
    assign w_drive       = REGS_EN & ~REGS_INC & ~REGS_RW;
    // Clearing the lowest set bit leaves something only if 2+ bits were set.
    assign w_multi_drive = |(w_drive & (w_drive - 8'd1));

    // Scan from the top so the lowest-index driver wins.
    always_comb begin
        w_bus_out = '0;
        for (int i = 7; i >= 0; i--) begin
            if (w_drive[i]) begin
                w_bus_out = r_regs[i];
            end
        end
    end

    assign BUS_OUT   = w_bus_out;
    assign BUS_DRIVE = |w_drive;
    assign REG_A     = r_regs[0];
    assign REG_B     = r_regs[1];

    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (REGS_EN[i]) begin
                    if (REGS_INC[i]) begin
                        r_regs[i] <= r_regs[i] + DATA_W'(1);
                    end else if (REGS_RW[i]) begin
                        r_regs[i] <= BUS_IN;
                    end
                end
            end
        end
    end

    // OUT FIFO: a full FIFO still accepts a push when a pop frees a slot on the
    // same edge; an empty FIFO ignores OUT_READY.
    assign w_valid    = (r_count != '0);
    assign w_full     = (r_count == C_CNT_W'(OUT_DEPTH));
    assign w_push_req = REGS_EN[7] & ~REGS_INC[7] & REGS_RW[7];
    assign w_pop      = w_valid & OUT_READY;
    assign w_push     = w_push_req & (~w_full | w_pop);

    assign OUT_VALID  = w_valid;
    assign OUT_DATA   = w_valid ? r_fifo[r_rd_ptr] : '0;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overrun  <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= BUS_IN;
                r_wr_ptr         <= r_wr_ptr + C_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + C_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - C_CNT_W'(1);
            end
            if (w_push_req && !w_push) begin
                r_overrun <= 1'b1;
            end
            if (w_multi_drive) begin
                r_conflict <= 1'b1;
            end
        end
    end

    assign OUT_OVERRUN  = r_overrun;
    assign BUS_CONFLICT = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_bat_amateur_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_bat_amateur_regfile
// Description : Self-checking bench for bat_amateur_regfile. Directed table of
//               load/increment/conflict vectors, hand sequences for the OUT
//               FIFO and mid-operation reset, then randomized strobes checked
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bat_amateur_regfile;

    localparam int C_DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] BUS_IN;
    logic [7:0] REGS_INC, REGS_RW, REGS_EN;
    logic [7:0] BUS_OUT;
    logic       BUS_DRIVE;
    logic [7:0] REG_A, REG_B, OUT_DATA;
    logic       OUT_VALID, OUT_READY, OUT_OVERRUN, BUS_CONFLICT;

    bat_amateur_regfile #(.DATA_W(8), .OUT_DEPTH(C_DEPTH)) dut (
        .CLK(CLK), .RST(RST), .BUS_IN(BUS_IN),
        .REGS_INC(REGS_INC), .REGS_RW(REGS_RW), .REGS_EN(REGS_EN),
        .BUS_OUT(BUS_OUT), .BUS_DRIVE(BUS_DRIVE),
        .REG_A(REG_A), .REG_B(REG_B),
        .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_OVERRUN(OUT_OVERRUN), .BUS_CONFLICT(BUS_CONFLICT)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    logic [7:0] m_regs [8];
    logic [7:0] m_q [$];
    logic       m_ovr;
    logic       m_conf;

    typedef struct {
        logic       rst_n;
        logic [7:0] en, inc, rw, bin;
        logic       rdy;
        logic [7:0] e_bus;
        logic       e_drv;
        logic [7:0] e_a, e_b;
        logic       e_conf;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [7:0] en, input logic [7:0] inc,
                         input logic [7:0] rw, input logic [7:0] bin, input logic rd);
        RST = r; REGS_EN = en; REGS_INC = inc; REGS_RW = rw; BUS_IN = bin; OUT_READY = rd;
        #1;
    endtask

    task automatic check_model();
        logic [7:0] e_bus;
        logic       e_drv;
        e_bus = 8'h00;
        e_drv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!e_drv && REGS_EN[i] && !REGS_INC[i] && !REGS_RW[i]) begin
                e_bus = m_regs[i];
                e_drv = 1'b1;
            end
        end
        chk("m_bus_out", BUS_OUT, e_bus);
        chk("m_bus_drive", BUS_DRIVE, e_drv);
        chk("m_reg_a", REG_A, m_regs[0]);
        chk("m_reg_b", REG_B, m_regs[1]);
        chk("m_out_valid", OUT_VALID, m_q.size() != 0);
        chk("m_out_data", OUT_DATA, (m_q.size() != 0) ? m_q[0] : 8'h00);
        chk("m_overrun", OUT_OVERRUN, m_ovr);
        chk("m_conflict", BUS_CONFLICT, m_conf);
    endtask

    // Advance one clock and apply the register-file rules to the model.
    task automatic tick();
        int  n_drv;
        logic push, pop;
        @(posedge CLK);
        if (!RST) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
            m_q.delete();
            m_ovr  = 1'b0;
            m_conf = 1'b0;
        end else begin
            n_drv = 0;
            for (int i = 0; i < 8; i++)
                if (REGS_EN[i] && !REGS_INC[i] && !REGS_RW[i]) n_drv++;
            if (n_drv >= 2) m_conf = 1'b1;
            push = REGS_EN[7] && !REGS_INC[7] && REGS_RW[7];
            pop  = (m_q.size() != 0) && OUT_READY;
            if (push && m_q.size() == C_DEPTH && !pop) m_ovr = 1'b1;
            if (pop) void'(m_q.pop_front());
            if (push && m_q.size() < C_DEPTH) m_q.push_back(BUS_IN);
            for (int i = 0; i < 8; i++) begin
                if (REGS_EN[i]) begin
                    if (REGS_INC[i])     m_regs[i] = 8'((int'(m_regs[i]) + 1) % 256);
                    else if (REGS_RW[i]) m_regs[i] = BUS_IN;
                end
            end
        end
        @(negedge CLK);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m_regs[i] = 8'hxx;
        m_ovr = 1'bx;
        m_conf = 1'bx;

        //            rst  en     inc    rw     bin    rdy  bus    drv  A      B      conf
        tbl[0] = '{1'b1, 8'h01, 8'h00, 8'h01, 8'h5A, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[1] = '{1'b1, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 8'h5A, 1'b1, 8'h5A, 8'h00, 1'b0};
        tbl[2] = '{1'b1, 8'h02, 8'h00, 8'h02, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h5A, 8'h00, 1'b0};
        tbl[3] = '{1'b1, 8'h02, 8'h02, 8'h02, 8'h33, 1'b0, 8'h00, 1'b0, 8'h5A, 8'hFF, 1'b0};
        tbl[4] = '{1'b1, 8'h01, 8'h00, 8'h01, 8'h11, 1'b0, 8'h00, 1'b0, 8'h5A, 8'h00, 1'b0};
        tbl[5] = '{1'b1, 8'h02, 8'h00, 8'h02, 8'h22, 1'b0, 8'h00, 1'b0, 8'h11, 8'h00, 1'b0};
        tbl[6] = '{1'b1, 8'h03, 8'h00, 8'h00, 8'h00, 1'b0, 8'h11, 1'b1, 8'h11, 8'h22, 1'b0};
        tbl[7] = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h11, 8'h22, 1'b1};
        tbl[8] = '{1'b1, 8'h02, 8'h00, 8'h00, 8'h00, 1'b0, 8'h22, 1'b1, 8'h11, 8'h22, 1'b1};

        // Power-up reset.
        drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        drive(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("reset_reg_a", REG_A, 8'h00);
        chk("reset_out_valid", OUT_VALID, 1'b0);
        chk("reset_out_data", OUT_DATA, 8'h00);
        chk("reset_flags", {OUT_OVERRUN, BUS_CONFLICT}, 2'b00);
        check_model();
        tick();

        // Directed load / increment-wrap / conflict table.
        for (int k = 0; k < 9; k++) begin
            drive(tbl[k].rst_n, tbl[k].en, tbl[k].inc, tbl[k].rw, tbl[k].bin, tbl[k].rdy);
            chk($sformatf("tbl%0d_bus_out", k), BUS_OUT, tbl[k].e_bus);
            chk($sformatf("tbl%0d_bus_drive", k), BUS_DRIVE, tbl[k].e_drv);
            chk($sformatf("tbl%0d_reg_a", k), REG_A, tbl[k].e_a);
            chk($sformatf("tbl%0d_reg_b", k), REG_B, tbl[k].e_b);
            chk($sformatf("tbl%0d_conflict", k), BUS_CONFLICT, tbl[k].e_conf);
            check_model();
            tick();
        end

        // OUT FIFO fill past capacity with the device stalled.
        drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 8'h80, 8'h00, 8'h80, 8'(k), 1'b0);
            if (k == 1) chk("fifo_first_valid_pre", OUT_VALID, 1'b0);
            if (k == 2) chk("fifo_first_valid_post", OUT_VALID, 1'b1);
            if (k == 5) chk("fifo_no_ovr_at_4", OUT_OVERRUN, 1'b0);
            check_model();
            tick();
        end
        drive(1'b1, 8'h80, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("fifo_reg7_on_bus", BUS_OUT, 8'h05);
        chk("fifo_full_head", OUT_DATA, 8'h01);
        chk("fifo_overrun", OUT_OVERRUN, 1'b1);
        check_model();
        tick();
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
            chk($sformatf("fifo_drain%0d", k), OUT_DATA, 8'(k));
            check_model();
            tick();
        end
        drive(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        chk("fifo_drained_valid", OUT_VALID, 1'b0);
        chk("fifo_overrun_sticky", OUT_OVERRUN, 1'b1);
        tick();

        // Push and pop on the same edge while full.
        drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 8'h80, 8'h00, 8'h80, 8'hA0 + 8'(k), 1'b0);
            tick();
        end
        drive(1'b1, 8'h80, 8'h00, 8'h80, 8'h99, 1'b1);
        chk("full_pp_head", OUT_DATA, 8'hA1);
        check_model();
        tick();
        begin
            logic [7:0] exp_seq [4];
            exp_seq[0] = 8'hA2; exp_seq[1] = 8'hA3; exp_seq[2] = 8'hA4; exp_seq[3] = 8'h99;
            for (int k = 0; k < 4; k++) begin
                drive(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
                chk($sformatf("full_pp_drain%0d", k), OUT_DATA, exp_seq[k]);
                chk($sformatf("full_pp_no_ovr%0d", k), OUT_OVERRUN, 1'b0);
                tick();
            end
        end
        drive(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("full_pp_empty", OUT_VALID, 1'b0);

        // Push with READY while empty: pop ignored, entry kept.
        drive(1'b1, 8'h80, 8'h00, 8'h80, 8'h3C, 1'b1);
        chk("empty_pp_valid_pre", OUT_VALID, 1'b0);
        tick();
        drive(1'b1, 8'h80, 8'h00, 8'h80, 8'h4D, 1'b0);
        chk("empty_pp_kept", OUT_DATA, 8'h3C);
        chk("empty_pp_valid", OUT_VALID, 1'b1);
        tick();

        // Reset in the middle of activity.
        drive(1'b1, 8'h03, 8'h00, 8'h03, 8'h12, 1'b0);
        tick();
        drive(1'b1, 8'h03, 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        drive(1'b0, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1);
        chk("rst_mid_bus_out", BUS_OUT, 8'h12);
        chk("rst_mid_conf_pre", BUS_CONFLICT, 1'b1);
        check_model();
        tick();
        drive(1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("rst_mid_bus_drive", BUS_DRIVE, 1'b1);
        chk("rst_mid_bus_zero", BUS_OUT, 8'h00);
        chk("rst_mid_regs", {REG_A, REG_B}, 16'h0000);
        chk("rst_mid_valid", OUT_VALID, 1'b0);
        chk("rst_mid_data", OUT_DATA, 8'h00);
        chk("rst_mid_flags", {OUT_OVERRUN, BUS_CONFLICT}, 2'b00);
        tick();

        // Randomized strobes against the reference model.
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 59) != 0),
                  8'($urandom), 8'($urandom & $urandom & $urandom), 8'($urandom),
                  8'($urandom), 1'($urandom_range(0, 1)));
            check_model();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
